// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants, state encoding and helpers for the multiply/divide unit
package multdiv_pkg;

   // Iterations per operation: one bit of the 32-bit operand per step
   localparam int ITERS = 32;

   // Most negative 32-bit value; the ALU overflow logic uses it too
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Magnitude of a signed 32-bit value as an unsigned 32-bit number.
   // MIN_INT maps to 0x80000000, which is exact when read as unsigned.
   function automatic logic [31:0] mag32(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/multdiv_addsub33.sv
// rtl/multdiv_addsub33.sv - 33-bit adder/subtractor shared by multiply, divide and negation
module multdiv_addsub33 (
   input  logic [32:0] i_a,
   input  logic [32:0] i_b,
   input  logic        i_sub,
   output logic [32:0] o_sum
);

   logic [32:0] w_b_inv;

   // Subtraction as a + ~b + 1 so a single carry chain serves both operations
   always_comb begin
      w_b_inv = i_b ^ {33{i_sub}};
      o_sum   = i_a + w_b_inv + {32'd0, i_sub};
   end

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed 32-bit multiply/divide unit with fixed 33-cycle latency
import multdiv_pkg::*;

module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_mult,
   input  logic             ctrl_div,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             result_rdy,
   output logic             busy
);

   localparam int                CNT_W = $clog2(ITERS);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(ITERS - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_count;
   // Multiply: {r_acc, r_q} is the 65-bit product register, r_q starts as the multiplier.
   // Divide: r_acc is the 33-bit partial remainder, r_q shifts dividend out and quotient in.
   logic [32:0]       r_acc;
   logic [31:0]       r_q;
   logic [32:0]       r_m;          // sign-extended multiplicand or divisor magnitude
   logic              r_is_div;
   logic              r_neg_q;      // quotient sign
   logic              r_div_zero;
   logic              r_div_ovf;    // MIN_INT / -1
   logic [31:0]       r_result;
   logic              r_exception;
   logic              r_rdy;
   logic              r_busy;

   logic              w_start;
   logic [32:0]       w_mag_b;
   logic [32:0]       w_add_a;
   logic [32:0]       w_add_b;
   logic              w_add_sub;
   logic [32:0]       w_sum;
   logic              w_mul_ovf;

   assign w_start   = ctrl_mult | ctrl_div;
   assign w_mag_b   = {1'b0, mag32(operand_b)};
   // Upper half of the 64-bit product must be the sign extension of the lower half
   assign w_mul_ovf = (r_acc[31:0] != {32{r_q[31]}});

   // Steer the shared adder according to the current phase of the operation
   always_comb begin
      w_add_a   = r_acc;
      w_add_b   = r_m;
      w_add_sub = 1'b0;
      case (r_state)
         ST_MUL: begin
            // Add the multiplicand for a set multiplier bit; the sign bit carries weight -2^31
            w_add_b   = r_q[0] ? r_m : 33'd0;
            w_add_sub = (r_count == LAST);
         end
         ST_DIV: begin
            // Non-restoring step: shift in the next dividend bit, subtract if remainder >= 0
            w_add_a   = {r_acc[31:0], r_q[31]};
            w_add_sub = ~r_acc[32];
         end
         ST_DONE: begin
            // Negate the quotient magnitude for the sign fix-up
            w_add_a   = 33'd0;
            w_add_b   = {1'b0, r_q};
            w_add_sub = 1'b1;
         end
         default: ;
      endcase
   end

   multdiv_addsub33 u_addsub (
      .i_a   (w_add_a),
      .i_b   (w_add_b),
      .i_sub (w_add_sub),
      .o_sum (w_sum)
   );

   // Control FSM with iteration datapath and registered outputs; a start pulse always wins
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_acc       <= '0;
         r_q         <= '0;
         r_m         <= '0;
         r_is_div    <= 1'b0;
         r_neg_q     <= 1'b0;
         r_div_zero  <= 1'b0;
         r_div_ovf   <= 1'b0;
         r_result    <= '0;
         r_exception <= 1'b0;
         r_rdy       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         if (w_start) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b1;
            r_neg_q    <= operand_a[31] ^ operand_b[31];
            r_div_zero <= (operand_b == 32'd0);
            r_div_ovf  <= (operand_a == MIN_INT) && (operand_b == 32'hFFFF_FFFF);
            if (ctrl_mult) begin
               r_state  <= ST_MUL;
               r_is_div <= 1'b0;
               r_q      <= operand_b;
               r_m      <= {operand_a[31], operand_a};
            end else begin
               r_state  <= ST_DIV;
               r_is_div <= 1'b1;
               r_q      <= mag32(operand_a);
               r_m      <= w_mag_b;
            end
         end else begin
            case (r_state)
               ST_MUL: begin
                  r_acc   <= {w_sum[32], w_sum[32:1]};
                  r_q     <= {w_sum[0], r_q[31:1]};
                  r_count <= r_count + 1'b1;
                  if (r_count == LAST) r_state <= ST_DONE;
               end
               ST_DIV: begin
                  r_acc   <= w_sum;
                  r_q     <= {r_q[30:0], ~w_sum[32]};
                  r_count <= r_count + 1'b1;
                  if (r_count == LAST) r_state <= ST_DONE;
               end
               ST_DONE: begin
                  if (!r_is_div) begin
                     r_result    <= r_q;
                     r_exception <= w_mul_ovf;
                  end else if (r_div_zero) begin
                     r_result    <= 32'd0;
                     r_exception <= 1'b1;
                  end else begin
                     r_result    <= r_neg_q ? w_sum[31:0] : r_q;
                     r_exception <= r_div_ovf;
                  end
                  r_rdy   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign result     = r_result;
   assign exception  = r_exception;
   assign result_rdy = r_rdy;
   assign busy       = r_busy;

endmodule
